// File: rtl/hus_bus_arb.sv
// hus_bus_arb: responder side of the sampler bus-request handshake.
// Requests the Z80 bus, waits for BUSAK, grants the sampler and serves
// single-word SRAM reads until the sampler lets go of busrq_n.
module hus_bus_arb #(
  parameter int unsigned AW       = 19,
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned TMO      = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          busrq_n,
  output logic          busak,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_ack,
  output logic [7:0]    rd_dat,
  output logic [7:0]    rd_cnt,
  output logic          tmo,
  output logic          cpu_busrq_n,
  input  logic          cpu_busak_n,
  output logic [AW-1:0] mem_a,
  output logic          mem_oe_n,
  input  logic [7:0]    mem_d,
  output logic          bus_en
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StReq   = 2'd1;
  localparam logic [1:0] StGrant = 2'd2;
  localparam logic [1:0] StRel   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [1:0]    ak_sync_q;
  logic          ak;
  logic [7:0]    tmo_cnt_q, tmo_cnt_d;
  logic          tmo_q, tmo_d;
  logic          busy_q, busy_d;
  logic [2:0]    wait_q, wait_d;
  logic [AW-1:0] mem_a_q, mem_a_d;
  logic          oe_n_q, oe_n_d;
  logic          ack_q, ack_d;
  logic [7:0]    dat_q, dat_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          rd_accept;
  logic          rd_last;

  // Two-flop synchronizer for the asynchronous Z80 BUSAK pin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ak_sync_q <= 2'b11;
    end else begin
      ak_sync_q <= {ak_sync_q[0], cpu_busak_n};
    end
  end

  assign ak = ~ak_sync_q[1];

  // Handshake FSM next state and grant timeout tracking.
  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = 8'd0;
    tmo_d     = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (!busrq_n) state_d = StReq;
      end
      StReq: begin
        // A withdrawn request wins over a simultaneous grant.
        if (busrq_n) begin
          state_d = StRel;
        end else if (ak) begin
          state_d = StGrant;
        end else begin
          tmo_cnt_d = (tmo_cnt_q == 8'(TMO)) ? tmo_cnt_q : tmo_cnt_q + 8'd1;
          if (tmo_cnt_q + 8'd1 == 8'(TMO)) tmo_d = 1'b1;
        end
      end
      StGrant: begin
        // An in-flight read always finishes before the bus is handed back.
        if (busrq_n && !busy_q) state_d = StRel;
      end
      StRel: begin
        if (!ak) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign rd_accept = (state_q == StGrant) && rd_req && !busy_q && !busrq_n;
  assign rd_last   = busy_q && (wait_q == 3'd0);

  // Read engine: hold mem_oe_n low MEM_WAIT+1 cycles, capture on the last one.
  always_comb begin
    busy_d  = busy_q;
    wait_d  = wait_q;
    mem_a_d = mem_a_q;
    oe_n_d  = oe_n_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    cnt_d   = cnt_q;
    if (rd_accept) begin
      busy_d  = 1'b1;
      wait_d  = 3'(MEM_WAIT);
      mem_a_d = rd_addr;
      oe_n_d  = 1'b0;
    end else if (rd_last) begin
      busy_d = 1'b0;
      oe_n_d = 1'b1;
      dat_d  = mem_d;
      ack_d  = 1'b1;
      if (cnt_q != 8'hff) cnt_d = cnt_q + 8'd1;
    end else if (busy_q) begin
      wait_d = wait_q - 3'd1;
    end
    if (state_q == StReq && state_d == StGrant) cnt_d = 8'd0;
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      tmo_cnt_q <= 8'd0;
      tmo_q     <= 1'b0;
      busy_q    <= 1'b0;
      wait_q    <= 3'd0;
      mem_a_q   <= '0;
      oe_n_q    <= 1'b1;
      ack_q     <= 1'b0;
      dat_q     <= 8'd0;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
      busy_q    <= busy_d;
      wait_q    <= wait_d;
      mem_a_q   <= mem_a_d;
      oe_n_q    <= oe_n_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      cnt_q     <= cnt_d;
    end
  end

  // Bus-side outputs decode straight from state so reset drops them at once.
  always_comb begin
    cpu_busrq_n = !((state_q == StReq) || (state_q == StGrant));
    busak       = (state_q == StGrant);
    bus_en      = (state_q == StGrant);
  end

  assign rd_ack   = ack_q;
  assign rd_dat   = dat_q;
  assign rd_cnt   = cnt_q;
  assign tmo      = tmo_q;
  assign mem_a    = mem_a_q;
  assign mem_oe_n = oe_n_q;

endmodule

// File: doc/hus_bus_arb.md
Name: hus_bus_arb

Overview:
- Responder side of the sampler's bus-request handshake.
- The sampler asserts busrq_n when it needs a sample burst. This block requests the bus from the Z80 and waits for its grant. It then answers with busak and serves single-word sample reads from external SRAM until the sampler releases the request.
- Sits between the hus sampler core, the Z80 BUSRQ/BUSAK pins and the SRAM address/data bus.

Parameters:
- AW, 19, SRAM address width
- MEM_WAIT, 1, extra clk cycles mem_oe_n is held low per read (0..7)
- TMO, 255, clk cycles allowed in ST_REQ before tmo is flagged (1..255)

Ports:
- clk  in  1  system clock (24 MHz)
- reset  in  1  asynchronous, active-low reset
- busrq_n  in  1  sampler bus request, active low, clk domain
- busak  out  1  grant to sampler, active high
- rd_req  in  1  single-cycle read strobe from sampler
- rd_addr  in  AW  read word address, sampled with rd_req
- rd_ack  out  1  single-cycle strobe, rd_dat valid
- rd_dat  out  8  read data
- rd_cnt  out  8  reads served in current grant, saturating
- tmo  out  1  sticky Z80 grant timeout flag
- cpu_busrq_n  out  1  to Z80 BUSRQ
- cpu_busak_n  in  1  from Z80 BUSAK, asynchronous
- mem_a  out  AW  SRAM address
- mem_oe_n  out  1  SRAM output enable
- mem_d  in  8  SRAM data
- bus_en  out  1  enables mem_a drivers onto the shared bus

Behaviour:
- Reset (reset low, async) values:
  - cpu_busrq_n=1, busak=0, bus_en=0, mem_oe_n=1
  - mem_a=0, rd_ack=0, rd_dat=0, rd_cnt=0, tmo=0
  - state=ST_IDLE
  - Reset mid-grant drops everything the same cycle; no graceful release.
- cpu_busak_n passes through a 2-flop synchronizer; ak = synchronized value == 0.
- FSM:
  - ST_IDLE: busrq_n==0 -> ST_REQ. cpu_busrq_n=1.
  - ST_REQ: cpu_busrq_n=0; timeout counter increments each cycle.
    - ak -> ST_GRANT; counter cleared.
    - Counter reaching TMO sets tmo (sticky until reset); the block keeps waiting.
    - busrq_n returns high before ak -> ST_REL.
  - ST_GRANT: busak=1, bus_en=1, cpu_busrq_n=0; rd_cnt cleared on entry; serves reads.
    - busrq_n==1 with no read active -> ST_REL.
    - busrq_n==1 with a read active: the read completes (rd_ack issued), then -> ST_REL.
  - ST_REL: busak=0, bus_en=0, cpu_busrq_n=1. Waits for !ak, then -> ST_IDLE.
    - busrq_n low again during ST_REL is held off until ST_IDLE is reached.
- Read engine (ST_GRANT only):
  - rd_req with engine idle: rd_addr latches into mem_a; mem_oe_n=0 for MEM_WAIT+1 cycles.
  - On the last low cycle: rd_dat<=mem_d, and rd_ack pulses the next cycle with mem_oe_n=1.
  - Latency rd_req -> rd_ack = MEM_WAIT+2 cycles.
  - Throughput: one read per MEM_WAIT+2 cycles; rd_req is accepted in the rd_ack cycle.
  - rd_req while busy or outside ST_GRANT is ignored; no ack is issued.
  - rd_cnt increments on each rd_ack and saturates at 255. It holds its value after release until the next grant.
  - rd_dat holds its value between reads.
- busak and bus_en are never high unless ak was seen and cpu_busrq_n is low.

Test Plan:
- Basic grant: reset, busrq_n=0, cpu_busak_n low 3 cycles after cpu_busrq_n falls -> busak rises 2 clk after cpu_busak_n falls (sync latency) + 1 state cycle; bus_en=1 with busak.
- Read latency: MEM_WAIT=1, rd_req with rd_addr=0x12345, mem_d=0xA5 -> mem_a=0x12345, mem_oe_n low 2 cycles, rd_ack 3 cycles after rd_req, rd_dat=0xA5, rd_cnt=1.
- Back-to-back: 32 reads issued on each rd_ack -> 32 acks, 3-cycle spacing, rd_cnt=32; a second rd_req mid-read produces no extra ack.
- Release mid-read: busrq_n high 1 cycle after rd_req -> rd_ack still issued; busak falls the next cycle; cpu_busrq_n=1; ST_IDLE reached only after cpu_busak_n goes high.
- Timeout: TMO=16, cpu_busak_n held high -> tmo=1 at cycle 16 in ST_REQ, cpu_busrq_n stays 0; later grant proceeds normally with tmo still 1.
- Async reset mid-grant: reset low during mem_oe_n=0 -> same-cycle cpu_busrq_n=1, busak=0, bus_en=0, mem_oe_n=1, rd_cnt=0, tmo=0.
